// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle adder/subtractor that works through an operand pair DIGIT
//   bits per clock, least significant digit first. A registered carry links
//   consecutive digits; each digit slice is a ripple of full_adder cells.
//
//   Ports
//     i_clk, i_rst_n        clock, synchronous active-low reset
//     i_valid / o_ready     operand handshake (o_ready high only in IDLE)
//     i_a, i_b              operands (WIDTH bits)
//     i_cin                 carry-in for addition, ignored for subtraction
//     i_sub                 0: A+B+cin, 1: A-B
//     o_valid / i_ready     result handshake (o_valid high only in DONE)
//     o_sum                 result, modulo 2^WIDTH
//     o_cout                carry out of the MSB (subtraction: 1 = no borrow)
//     o_ovf                 two's-complement overflow
//     o_busy                high in RUN or DONE
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | waiting for i_valid, o_ready=1
//   RUN   | one digit processed per clock, counter 0..K-1
//   DONE  | result held with o_valid=1 until i_ready

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic [DIGIT:0]   c;
  logic             last;

  // Digit selection by shift keeps the select in range even when K=1.
  assign dig_a = DIGIT'(a_q >> (int'(cnt_q) * DIGIT));
  assign dig_b = DIGIT'(b_q >> (int'(cnt_q) * DIGIT));
  assign last  = (cnt_q == CW'(K - 1));

  assign c[0] = carry_q;
  generate
    for (genvar g = 0; g < DIGIT; g++) begin : g_fa
      full_adder u_fa (
        .a  (dig_a[g]),
        .b  (dig_b[g]),
        .ci (c[g]),
        .s  (dig_s[g]),
        .co (c[g+1])
      );
    end
  endgenerate

  // Current digit merged into the partial result; on the last digit this is
  // the complete sum.
  always_comb begin
    res_d = res_q;
    for (int i = 0; i < K; i++) begin
      if (int'(cnt_q) == i) res_d[i*DIGIT +: DIGIT] = dig_s;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_valid) state_d = S_RUN;
      S_RUN:   if (last)    state_d = S_DONE;
      S_DONE:  if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            a_q     <= i_a;
            // Subtraction as A + ~B + 1.
            b_q     <= i_sub ? ~i_b : i_b;
            carry_q <= i_sub | i_cin;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          res_q   <= res_d;
          carry_q <= c[DIGIT];
          if (last) begin
            cnt_q  <= '0;
            sum_q  <= res_d;
            cout_q <= c[DIGIT];
            // Carry into the MSB is the second-to-last ripple tap; for DIGIT=1
            // that is the registered carry itself.
            ovf_q  <= c[DIGIT-1] ^ c[DIGIT];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_busy  = (state_q != S_IDLE);
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_ovf   = ovf_q;

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor that processes an operand pair DIGIT bits per clock, LSB digit first. A registered carry links consecutive digits. Each digit slice is a ripple of DIGIT 1-bit full_adder cells. The block sits in the arithmetic utilities layer as an area-efficient alternative to a full-width combinational adder. It uses valid/ready handshakes on input and output.

## Interface
- WIDTH, 16: operand and result width in bits; must be a positive multiple of DIGIT (elaboration error otherwise).
- DIGIT, 4: bits processed per cycle, 1 ≤ DIGIT ≤ WIDTH; K = WIDTH/DIGIT cycles per operation.

- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  operand request.
- o_ready  out  1  block can accept; high only in IDLE.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_cin  in  1  carry-in for addition; ignored when i_sub=1.
- i_sub  in  1  0: A+B+cin, 1: A−B.
- o_valid  out  1  result available; high only in DONE.
- i_ready  in  1  consumer accepts result.
- o_sum  out  WIDTH  result, LSBs of the sum.
- o_cout  out  1  carry out of MSB (sub: 1 = no borrow).
- o_ovf  out  1  two's-complement overflow.
- o_busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: o_ready=1.
  - RUN: processing digits; internal counter 0..K−1.
  - DONE: o_valid=1.
- IDLE → RUN on an edge with i_valid=1. A, B (B inverted if i_sub), and carry register are latched on that edge. Carry register = 1 if i_sub, else i_cin. Digit counter = 0.
- RUN:
  - Each edge adds digit d of A, digit d of B', and the carry register through a DIGIT-wide full_adder ripple.
  - The digit result is stored into internal bits [d*DIGIT +: DIGIT].
  - The carry register takes the digit carry-out, and the counter increments.
  - On the edge that processes digit K−1, the state goes to DONE. On that same edge the registered outputs load:
    - o_sum = assembled result;
    - o_cout = final carry;
    - o_ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- DONE: outputs stay stable while i_ready=0. On an edge with i_ready=1, the state goes to IDLE.
- Inputs i_a/i_b/i_cin/i_sub are sampled only at the accept edge; changes afterwards have no effect.
- i_valid is ignored outside IDLE (o_ready=0). There is no accept in the same cycle as the DONE→IDLE handshake.
- o_sum/o_cout/o_ovf hold their last completed result through IDLE and RUN until the next completion.
- Arithmetic is modulo 2^WIDTH. The carry-into-MSB is tapped inside the last digit slice; for DIGIT=1 it is the carry register value entering that digit.

## Timing
- Reset: any edge with i_rst_n=0 gives state IDLE and counter 0. Outputs after reset: o_valid=0, o_busy=0, o_ready=1, o_sum=0, o_cout=0, o_ovf=0. Internal operand and carry registers are cleared.
- Reset mid-RUN or mid-DONE aborts silently; no o_valid is produced for the aborted operation.
- Latency: accept at edge E0 → o_valid high in the cycle after edge EK. That is K cycles after acceptance (K=4 at defaults).
- Throughput with i_ready tied high: one operation per K+2 cycles.
- K=1 (DIGIT=WIDTH): a single RUN cycle; behaviour is otherwise identical.
- o_ready and o_valid are decoded from the state register, with no combinational path from inputs. o_sum/o_cout/o_ovf are registered.

## Test plan
- Add, WIDTH=16, DIGIT=4: A=0x1234, B=0x0FFF, cin=0 → o_sum=0x2233, o_cout=0, o_ovf=0. o_valid rises exactly 4 cycles after the accept edge.
- Carry chain across all digits: A=0xFFFF, B=0x0001, cin=1 → o_sum=0x0001, o_cout=1, o_ovf=0. Separately, A=0x7FFF, B=0x0001, cin=0 → o_sum=0x8000, o_cout=0, o_ovf=1.
- Subtract: A=0x8000, B=0x0001, i_sub=1, i_cin=1 (must be ignored) → o_sum=0x7FFF, o_cout=1, o_ovf=1. Separately, A=0x0003, B=0x0005 → o_sum=0xFFFE, o_cout=0, o_ovf=0.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while toggling i_valid and operands.
  - Required: o_valid=1, o_ready=0, and outputs stable throughout.
  - On the i_ready=1 edge → IDLE; o_ready=1 next cycle.
  - The next operation returns its own correct result.
- Reset mid-RUN: drive i_rst_n=0 for one edge after digit 1 is processed.
  - Required: o_valid never asserts for that operation; all outputs hold their reset values.
  - A following op, 0x00FF+0x0001, gives 0x0100.
- Parameter sweep with random operands, checked against a reference model, 200 ops each: WIDTH=8/DIGIT=1 (K=8), WIDTH=8/DIGIT=8 (K=1), and WIDTH=32/DIGIT=8.
